// File: rtl/inert_spi_seq.sv
// inert_spi_seq: IMU command sequencer driving the SPI monarch (boot wait, config writes, INT-triggered rate reads).
// Define ACCEL_RD_EN to also read accel X/Y (regs 0x28-0x2B) into AX/AY; undefined, AX/AY are tied to zero.
module inert_spi_seq #(
    parameter int unsigned STARTUP_BITS = 16,
    parameter int unsigned GAP_CLKS     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic [15:0] AX,
    output logic [15:0] AY,
    output logic        vld
);
`ifdef ACCEL_RD_EN
    localparam int unsigned N_RD = 10;
`else
    localparam int unsigned N_RD = 6;
`endif
    localparam int unsigned N_INIT = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SIDX_W = $clog2(N_RD);
    localparam int unsigned GAP_W  = $clog2(GAP_CLKS + 1);

    typedef enum logic [3:0] {
        BOOT, INIT_WR, INIT_WT, INIT_GAP, WAIT_INT, RD, RD_WT, RD_GAP, VLD
    } state_t;

    state_t                  state, state_nxt;
    logic [STARTUP_BITS-1:0] boot_cnt, boot_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    int_ff1, int_ff2, int_ff3;
    logic                    int_rise_c, gap_last_c;
    logic                    wrt_nxt, vld_nxt;
    logic [15:0]             cmd_nxt;
    logic [7:0]              stage [N_RD];
    logic [7:0]              stage_nxt [N_RD];
    logic                    unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];
    assign int_rise_c   = int_ff2 & ~int_ff3;
    assign gap_last_c   = (gap_cnt == GAP_W'(GAP_CLKS - 1));

    function automatic logic [15:0] init_cmd(input logic [IDX_W-1:0] i);
        case (i)
            IDX_W'(0): init_cmd = 16'h0D02;
            IDX_W'(1): init_cmd = 16'h1062;
            IDX_W'(2): init_cmd = 16'h1162;
            default:   init_cmd = 16'h1460;
        endcase
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [IDX_W-1:0] i);
        rd_cmd = {1'b1, 7'(7'h22 + 7'(i)), 8'h00};
    endfunction

    // Next-state, counters, command/strobe and byte staging
    always_comb begin
        state_nxt = state;
        boot_nxt  = boot_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        wrt_nxt   = 1'b0;
        cmd_nxt   = cmd;
        stage_nxt = stage;
        case (state)
            BOOT: begin
                if (boot_cnt == '1) begin
                    idx_nxt   = '0;
                    state_nxt = INIT_WR;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = init_cmd('0);
                end else begin
                    boot_nxt = boot_cnt + 1'b1;
                end
            end
            INIT_WR: state_nxt = INIT_WT;
            INIT_WT: begin
                if (done) begin
                    gap_nxt   = '0;
                    state_nxt = INIT_GAP;
                end
            end
            INIT_GAP: begin
                if (!gap_last_c) begin
                    gap_nxt = gap_cnt + 1'b1;
                end else if (idx == IDX_W'(N_INIT - 1)) begin
                    state_nxt = WAIT_INT;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = INIT_WR;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = init_cmd(idx + 1'b1);
                end
            end
            WAIT_INT: begin
                if (int_rise_c) begin
                    idx_nxt   = '0;
                    state_nxt = RD;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = rd_cmd('0);
                end
            end
            RD: state_nxt = RD_WT;
            RD_WT: begin
                if (done) begin
                    stage_nxt[SIDX_W'(idx)] = rd_data[7:0];
                    gap_nxt                 = '0;
                    state_nxt               = RD_GAP;
                end
            end
            RD_GAP: begin
                if (!gap_last_c) begin
                    gap_nxt = gap_cnt + 1'b1;
                end else if (idx == IDX_W'(N_RD - 1)) begin
                    state_nxt = VLD;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = RD;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = rd_cmd(idx + 1'b1);
                end
            end
            VLD:     state_nxt = WAIT_INT;
            default: state_nxt = BOOT;
        endcase
        // VLD lasts one clk, so entering it is the single output-load point
        vld_nxt = (state_nxt == VLD) && (state != VLD);
    end

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            int_ff1  <= 1'b0;
            int_ff2  <= 1'b0;
            int_ff3  <= 1'b0;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
            vld      <= 1'b0;
            stage    <= '{default: '0};
            ptch_rt  <= 16'h0000;
            roll_rt  <= 16'h0000;
            yaw_rt   <= 16'h0000;
`ifdef ACCEL_RD_EN
            AX       <= 16'h0000;
            AY       <= 16'h0000;
`endif
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_nxt;
            gap_cnt  <= gap_nxt;
            idx      <= idx_nxt;
            int_ff1  <= INT;
            int_ff2  <= int_ff1;
            int_ff3  <= int_ff2;
            wrt      <= wrt_nxt;
            cmd      <= cmd_nxt;
            vld      <= vld_nxt;
            stage    <= stage_nxt;
            if (vld_nxt) begin
                roll_rt <= {stage[1], stage[0]};
                ptch_rt <= {stage[3], stage[2]};
                yaw_rt  <= {stage[5], stage[4]};
`ifdef ACCEL_RD_EN
                AX      <= {stage[7], stage[6]};
                AY      <= {stage[9], stage[8]};
`endif
            end
        end
    end

`ifndef ACCEL_RD_EN
    assign AX = 16'h0000;
    assign AY = 16'h0000;
`endif

endmodule

// File: tb/tb_inert_spi_seq.sv
// tb_inert_spi_seq: directed sequence with randomized IMU register data and SPI monarch latency,
// checked against a register-map level model of the expected command stream and assembled rates.
module tb_inert_spi_seq;
    localparam int unsigned SB  = 4;
    localparam int unsigned GAP = 8;
`ifdef ACCEL_RD_EN
    localparam int N_RD = 10;
`else
    localparam int N_RD = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld;
    logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt, AX, AY;

    inert_spi_seq #(.STARTUP_BITS(SB), .GAP_CLKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
        .AX(AX), .AY(AY), .vld(vld)
    );

    initial forever #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // IMU register map seen through the monarch
    logic [7:0]  regs [128];
    logic [15:0] init_tbl [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

    // Observation logs
    logic [15:0] wrt_cmd_q [$];
    int          wrt_cyc_q [$];
    int          done_cyc_q [$];
    logic [15:0] snap_q [$];
    int          vld_n = 0, wide_wrt = 0, wide_vld = 0, cmd_drift = 0;
    int          spur_req = 0, spur_done = 0;

    initial begin : mon
        bit wp = 0;
        bit vp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wp = 0;
                vp = 0;
            end else begin
                if (wrt) begin
                    wrt_cmd_q.push_back(cmd);
                    wrt_cyc_q.push_back(cyc);
                    if (wp) wide_wrt++;
                end
                if (vld) begin
                    vld_n++;
                    snap_q.push_back(roll_rt);
                    snap_q.push_back(ptch_rt);
                    snap_q.push_back(yaw_rt);
                    snap_q.push_back(AX);
                    snap_q.push_back(AY);
                    if (vp) wide_vld++;
                end
                wp = wrt;
                vp = vld;
            end
        end
    end

    // SPI monarch model: random latency, 1-clk done, read data from regs
    initial begin : monarch
        bit          busy = 0;
        int          lat = 0;
        logic [15:0] bcmd = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (busy) begin
                if (lat == 0) begin
                    done    = 1'b1;
                    rd_data = {8'($urandom), bcmd[15] ? regs[bcmd[14:8]] : 8'h00};
                    done_cyc_q.push_back(cyc);
                    if (cmd !== bcmd) cmd_drift++;
                    busy = 0;
                end else begin
                    lat--;
                end
            end else if (wrt) begin
                busy = 1;
                bcmd = cmd;
                lat  = int'($urandom_range(2, 8));
            end else if (spur_done != spur_req) begin
                done    = 1'b1;
                rd_data = 16'($urandom);
                spur_done++;
            end
        end
    end

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] exp_roll = 0, exp_ptch = 0, exp_yaw = 0, exp_ax = 0, exp_ay = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_wrts(input int n, input int budget, input string tag);
        int k = 0;
        while (wrt_cmd_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(wrt_cmd_q.size() >= n), 32'd1);
    endtask

    task automatic wait_vld(input int n, input int budget, input string tag);
        int k = 0;
        while (vld_n < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(vld_n >= n), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wrt"}, 32'(wrt), 32'd0);
        chk({tag, "_vld"}, 32'(vld), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'd0);
        chk({tag, "_rates"}, 32'({roll_rt | ptch_rt | yaw_rt | AX | AY}), 32'd0);
    endtask

    task automatic chk_min_gap(input int wbase, input int dbase, input int n, input string tag);
        int mg = 1 << 30;
        for (int i = 1; i < n; i++)
            if (wrt_cyc_q[wbase + i] - done_cyc_q[dbase + i - 1] < mg)
                mg = wrt_cyc_q[wbase + i] - done_cyc_q[dbase + i - 1];
        chk(tag, 32'(mg >= int'(GAP)), 32'd1);
    endtask

    // Boot delay then the four config writes in table order
    task automatic boot_and_init(input int t0, input string tag);
        int wb = wrt_cmd_q.size();
        int db = done_cyc_q.size();
        int d;
        wait_wrts(wb + 1, 200, {tag, "_first_wrt"});
        d = wrt_cyc_q[wb] - t0;
        chk({tag, "_boot_delay"}, 32'(d >= (1 << SB) - 1 && d <= (1 << SB)), 32'd1);
        wait_wrts(wb + 4, 600, {tag, "_init_wrts"});
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_init_cmd%0d", tag, i), 32'(wrt_cmd_q[wb + i]), 32'(init_tbl[i]));
        repeat (60) tick();
        chk({tag, "_init_count"}, 32'(wrt_cmd_q.size()), 32'(wb + 4));
        chk_min_gap(wb, db, 4, {tag, "_init_gap"});
    endtask

    task automatic randomize_regs();
        for (int a = 'h22; a <= 'h2B; a++) regs[7'(a)] = 8'($urandom);
    endtask

    task automatic run_set(input string tag, input bit mid, input bit hold);
        int wb = wrt_cmd_q.size();
        int db = done_cyc_q.size();
        int vb = vld_n;
        logic [15:0] nr, np, ny, nx, nyy;
        nr  = {regs[7'h23], regs[7'h22]};
        np  = {regs[7'h25], regs[7'h24]};
        ny  = {regs[7'h27], regs[7'h26]};
`ifdef ACCEL_RD_EN
        nx  = {regs[7'h29], regs[7'h28]};
        nyy = {regs[7'h2B], regs[7'h2A]};
`else
        nx  = 16'h0000;
        nyy = 16'h0000;
`endif
        INT = 1'b1;
        if (!hold) begin
            repeat (2) tick();
            INT = 1'b0;
        end
        if (mid) begin
            wait_wrts(wb + 2, 400, {tag, "_mid_wait"});
            INT = 1'b1;
            repeat (3) tick();
            INT = 1'b0;
            chk({tag, "_mid_roll_held"}, 32'(roll_rt), 32'(exp_roll));
            chk({tag, "_mid_yaw_held"}, 32'(yaw_rt), 32'(exp_yaw));
            chk({tag, "_mid_no_vld"}, 32'(vld_n), 32'(vb));
        end
        wait_vld(vb + 1, 3000, {tag, "_vld_wait"});
        if (snap_q.size() >= 5 * (vb + 1)) begin
            chk({tag, "_roll"}, 32'(snap_q[5 * vb + 0]), 32'(nr));
            chk({tag, "_ptch"}, 32'(snap_q[5 * vb + 1]), 32'(np));
            chk({tag, "_yaw"},  32'(snap_q[5 * vb + 2]), 32'(ny));
            chk({tag, "_ax"},   32'(snap_q[5 * vb + 3]), 32'(nx));
            chk({tag, "_ay"},   32'(snap_q[5 * vb + 4]), 32'(nyy));
        end
        repeat (150) tick();
        chk({tag, "_vld_count"}, 32'(vld_n), 32'(vb + 1));
        chk({tag, "_wrt_count"}, 32'(wrt_cmd_q.size()), 32'(wb + N_RD));
        chk({tag, "_roll_kept"}, 32'(roll_rt), 32'(nr));
        if (wrt_cmd_q.size() >= wb + N_RD) begin
            for (int i = 0; i < N_RD; i++)
                chk($sformatf("%s_rd_cmd%0d", tag, i), 32'(wrt_cmd_q[wb + i]),
                    32'({1'b1, 7'(7'h22 + i), 8'h00}));
            chk_min_gap(wb, db, N_RD, {tag, "_rd_gap"});
        end
        INT = 1'b0;
        exp_roll = nr; exp_ptch = np; exp_yaw = ny; exp_ax = nx; exp_ay = nyy;
    endtask

    initial begin : main
        int t0, wb;
        for (int a = 0; a < 128; a++) regs[a] = 8'($urandom);

        repeat (3) tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        t0 = cyc;
        spur_req++;
        boot_and_init(t0, "pwr");

        regs[7'h22] = 8'h34; regs[7'h23] = 8'h12;
        regs[7'h26] = 8'hFF; regs[7'h27] = 8'h80;
        run_set("set0", 1'b0, 1'b0);
        chk("set0_roll_1234", 32'(roll_rt), 32'h1234);
        chk("set0_yaw_80ff", 32'(yaw_rt), 32'h80FF);

        randomize_regs();
        run_set("set1_mid_int", 1'b1, 1'b0);
        randomize_regs();
        run_set("set2_hold_int", 1'b0, 1'b1);

        wb = wrt_cmd_q.size();
        spur_req++;
        repeat (10) tick();
        chk("spur_done_no_wrt", 32'(wrt_cmd_q.size()), 32'(wb));
        randomize_regs();
        run_set("set3", 1'b0, 1'b0);

        // Reset while a read is in flight
        wb = wrt_cmd_q.size();
        randomize_regs();
        INT = 1'b1;
        repeat (2) tick();
        INT = 1'b0;
        wait_wrts(wb + 3, 400, "rst_mid_wait");
        tick();
        #3 rst_n = 1'b0;
        #1 chk_zero_outputs("rst_mid");
        repeat (3) tick();
        rst_n = 1'b1;
        t0 = cyc;
        exp_roll = 0; exp_ptch = 0; exp_yaw = 0; exp_ax = 0; exp_ay = 0;
        boot_and_init(t0, "rst_rel");
        randomize_regs();
        run_set("set4", 1'b0, 1'b0);

        chk("wrt_single_clk", 32'(wide_wrt), 32'd0);
        chk("vld_single_clk", 32'(wide_vld), 32'd0);
        chk("cmd_stable", 32'(cmd_drift), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
